// File: rtl/gesture_photo_stepper_pkg.sv
// Shared definitions for the swipe-gesture photo stepper: gesture codes,
// FSM state encoding and the slide-direction type.
package gesture_photo_stepper_pkg;

    localparam logic [1:0] GEST_NONE = 2'b00;
    localparam logic [1:0] GEST_NEXT = 2'b10;
    localparam logic [1:0] GEST_PREV = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SLIDE = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

    typedef enum logic {
        DIR_PREV = 1'b0,
        DIR_NEXT = 1'b1
    } dir_t;

    function automatic logic is_step_code(input logic [1:0] code);
        return (code == GEST_NEXT) || (code == GEST_PREV);
    endfunction

endpackage

// File: rtl/gesture_photo_stepper_if.sv
// Gesture-detector to photo-stepper link: gesture code/trigger inbound,
// photo index and slide status outbound.
interface gesture_photo_stepper_if #(
    parameter int IDX_W = 3,
    parameter int CNT_W = 8
);
    logic [1:0]       iGESTURE;
    logic             iTRIGGER;
    logic [IDX_W-1:0] oPHOTO_NUM;
    logic             oSLIDE_BUSY;
    logic             oSLIDE_DIR;
    logic [CNT_W-1:0] oSLIDE_POS;
    logic             oSTEP;

    modport master (
        output iGESTURE,
        output iTRIGGER,
        input  oPHOTO_NUM,
        input  oSLIDE_BUSY,
        input  oSLIDE_DIR,
        input  oSLIDE_POS,
        input  oSTEP
    );

    modport slave (
        input  iGESTURE,
        input  iTRIGGER,
        output oPHOTO_NUM,
        output oSLIDE_BUSY,
        output oSLIDE_DIR,
        output oSLIDE_POS,
        output oSTEP
    );
endinterface

// File: rtl/gesture_photo_stepper_gesture_sync.sv
// Two-flop synchroniser for the gesture code and trigger from the divided
// clock domain, plus a registered rising-edge event with its sampled code.
module gesture_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trig_i,
    input  logic [1:0] gest_i,
    output logic       trig_o,
    output logic       evt_o,
    output logic [1:0] code_o
);

    logic       trig_s1_q, trig_s1_d;
    logic       trig_s2_q, trig_s2_d;
    logic       trig_s3_q, trig_s3_d;
    logic [1:0] gest_s1_q, gest_s1_d;
    logic [1:0] gest_s2_q, gest_s2_d;
    logic       evt_q,     evt_d;
    logic [1:0] code_q,    code_d;

    always_comb begin
        trig_s1_d = trig_i;
        trig_s2_d = trig_s1_q;
        trig_s3_d = trig_s2_q;
        gest_s1_d = gest_i;
        gest_s2_d = gest_s1_q;
        // Event and its code are registered together so the FSM sees a
        // code that belongs to the same synced sample as the edge.
        evt_d     = trig_s2_q & ~trig_s3_q;
        code_d    = gest_s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_s1_q <= 1'b0;
            trig_s2_q <= 1'b0;
            trig_s3_q <= 1'b0;
            gest_s1_q <= '0;
            gest_s2_q <= '0;
            evt_q     <= 1'b0;
            code_q    <= '0;
        end else begin
            trig_s1_q <= trig_s1_d;
            trig_s2_q <= trig_s2_d;
            trig_s3_q <= trig_s3_d;
            gest_s1_q <= gest_s1_d;
            gest_s2_q <= gest_s2_d;
            evt_q     <= evt_d;
            code_q    <= code_d;
        end
    end

    assign trig_o = trig_s2_q;
    assign evt_o  = evt_q;
    assign code_o = code_q;

endmodule

// File: rtl/gesture_photo_stepper.sv
// Photo stepper: IDLE -> SLIDE -> LOCK per accepted swipe gesture.
// Define GESTURE_STEP_WRAP_EN to wrap the index at the ends; default saturates.
module gesture_photo_stepper
    import gesture_photo_stepper_pkg::*;
#(
    parameter int NUM_PHOTOS     = 8,
    parameter int IDX_W          = 3,
    parameter int SLIDE_CYCLES   = 16,
    parameter int LOCKOUT_CYCLES = 32,
    parameter int CNT_W          = 8
) (
    input  logic                     clk,
    input  logic                     iRST_n,
    gesture_photo_stepper_if.slave   bus
);

    localparam logic [IDX_W-1:0] IDX_MAX    = IDX_W'(NUM_PHOTOS - 1);
    localparam logic [CNT_W-1:0] SLIDE_LAST = CNT_W'(SLIDE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCKOUT_CYCLES - 1);

    logic       trig_sync;
    logic       evt;
    logic [1:0] code;

    gesture_sync u_sync (
        .clk    (clk),
        .rst_n  (iRST_n),
        .trig_i (bus.iTRIGGER),
        .gest_i (bus.iGESTURE),
        .trig_o (trig_sync),
        .evt_o  (evt),
        .code_o (code)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    dir_t             dir_q,   dir_d;
    logic             step_q,  step_d;

    logic             accept;
    logic             slide_done;
    logic             lock_done;
    logic [IDX_W-1:0] idx_inc;
    logic [IDX_W-1:0] idx_dec;

    always_comb begin
        idx_inc = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        idx_dec = (idx_q == '0) ? IDX_MAX : idx_q - IDX_W'(1);
`ifdef GESTURE_STEP_WRAP_EN
        accept = evt && is_step_code(code);
`else
        // Boundary gestures are rejected here; the edge is still consumed.
        accept = evt && (((code == GEST_NEXT) && (idx_q != IDX_MAX)) ||
                         ((code == GEST_PREV) && (idx_q != '0)));
`endif
        slide_done = (timer_q == SLIDE_LAST);
        lock_done  = (timer_q == LOCK_LAST) && !trig_sync;
    end

    always_ff @(posedge clk or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept)     state_d = ST_SLIDE;
            ST_SLIDE: if (slide_done) state_d = ST_LOCK;
            ST_LOCK:  if (lock_done)  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        timer_d = timer_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (accept) begin
                    dir_d = (code == GEST_NEXT) ? DIR_NEXT : DIR_PREV;
                end
            end
            ST_SLIDE: begin
                if (slide_done) begin
                    timer_d = '0;
                    step_d  = 1'b1;
                    idx_d   = (dir_q == DIR_NEXT) ? idx_inc : idx_dec;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            ST_LOCK: begin
                // Timer parks at its last value while the trigger is still held.
                if (lock_done) begin
                    timer_d = '0;
                end else if (timer_q != LOCK_LAST) begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            default: timer_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge iRST_n) begin
        if (!iRST_n) begin
            timer_q <= '0;
            idx_q   <= '0;
            dir_q   <= DIR_PREV;
            step_q  <= 1'b0;
        end else begin
            timer_q <= timer_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
        end
    end

    assign bus.oSLIDE_BUSY = (state_q == ST_SLIDE);
    assign bus.oSLIDE_POS  = (state_q == ST_SLIDE) ? timer_q : '0;
    assign bus.oSLIDE_DIR  = dir_q;
    assign bus.oPHOTO_NUM  = idx_q;
    assign bus.oSTEP       = step_q;

endmodule

// File: tb/tb_gesture_photo_stepper.sv
// Self-checking bench for gesture_photo_stepper: gesture table, corner-case
// sequences and random traffic against a timestamp-based reference model.
module tb_gesture_photo_stepper;

    localparam int NP = 4;
    localparam int IW = 2;
    localparam int SL = 4;
    localparam int LK = 8;
    localparam int CW = 8;
`ifdef GESTURE_STEP_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gesture_photo_stepper_if #(.IDX_W(IW), .CNT_W(CW)) bus ();

    gesture_photo_stepper #(
        .NUM_PHOTOS    (NP),
        .IDX_W         (IW),
        .SLIDE_CYCLES  (SL),
        .LOCKOUT_CYCLES(LK),
        .CNT_W         (CW)
    ) dut (
        .clk    (clk),
        .iRST_n (rst_n),
        .bus    (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per-cycle input history plus the edge index at which
    // the last gesture was accepted; outputs follow from time arithmetic.
    bit         trig_h[$];
    logic [1:0] gest_h[$];
    bit         pending;
    bit         have_acc;
    int         acc;
    bit         acc_dir;
    int         cur_idx;
    int         new_idx;
    int         busy_cnt;
    int         step_cnt;

    function automatic bit tr(int i);
        return (i < 0) ? 1'b0 : trig_h[i];
    endfunction

    function automatic logic [1:0] gs(int i);
        return (i < 0) ? 2'b00 : gest_h[i];
    endfunction

    task automatic model_reset();
        trig_h.delete();
        gest_h.delete();
        pending  = 1'b0;
        have_acc = 1'b0;
        acc      = 0;
        acc_dir  = 1'b0;
        cur_idx  = 0;
        new_idx  = 0;
    endtask

    task automatic tick(input bit trig, input logic [1:0] g);
        int         t;
        int         target;
        logic [1:0] c;
        bit         eb, es, ed, ok;
        int         ep;
        @(negedge clk);
        bus.iTRIGGER = trig;
        bus.iGESTURE = g;
        trig_h.push_back(trig);
        gest_h.push_back(g);
        @(posedge clk);
        #1;
        t = trig_h.size() - 1;
        // Rising edge on the input reaches the FSM three edges later.
        if (tr(t - 3) && !tr(t - 4) && !pending) begin
            c = gs(t - 3);
            target = -1;
            if (c == 2'b10) begin
                target = cur_idx + 1;
                if (target == NP) target = WRAP ? 0 : -1;
            end else if (c == 2'b01) begin
                target = cur_idx - 1;
                if (target < 0) target = WRAP ? NP - 1 : -1;
            end
            if (target >= 0) begin
                pending  = 1'b1;
                have_acc = 1'b1;
                acc      = t;
                acc_dir  = (c == 2'b10);
                new_idx  = target;
            end
        end
        es = have_acc && (t == acc + SL);
        if (es) cur_idx = new_idx;
        eb = have_acc && (t >= acc) && (t < acc + SL);
        ep = eb ? t - acc : 0;
        ed = acc_dir;
        if (pending && (t >= acc + SL + LK) && !tr(t - 2)) pending = 1'b0;

        busy_cnt += int'(bus.oSLIDE_BUSY);
        step_cnt += int'(bus.oSTEP);
        checks++;
        ok = (bus.oSLIDE_BUSY == eb) && (bus.oSTEP == es) &&
             (int'(bus.oSLIDE_POS) == ep) && (int'(bus.oPHOTO_NUM) == cur_idx) &&
             (!eb || (bus.oSLIDE_DIR == ed));
        if (!ok) begin
            errors++;
            $display("FAIL cycle t=%0d busy/dir/pos/step/idx got %0b/%0b/%0d/%0b/%0d want %0b/%0b/%0d/%0b/%0d",
                     t, bus.oSLIDE_BUSY, bus.oSLIDE_DIR, bus.oSLIDE_POS, bus.oSTEP, bus.oPHOTO_NUM,
                     eb, ed, ep, es, cur_idx);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.iTRIGGER = 1'b0;
        bus.iGESTURE = 2'b00;
        #1;
        check_int("reset_outputs",
                  {bus.oSLIDE_BUSY, bus.oSTEP, bus.oSLIDE_DIR} | int'(bus.oSLIDE_POS) | int'(bus.oPHOTO_NUM), 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic do_gesture(input logic [1:0] code, input int hold);
        busy_cnt = 0;
        step_cnt = 0;
        repeat (hold) tick(1'b1, code);
        repeat (25) tick(1'b0, 2'b00);
    endtask

    typedef struct {
        bit         rst;
        logic [1:0] code;
        int         exp_idx;
        int         exp_steps;
        int         exp_busy;
    } vec_t;

    vec_t vecs[9];

    initial begin
        bit seen;
        int hold, gap;
        logic [1:0] g;

        vecs[0] = '{1'b1, 2'b10, 1, 1, SL};
        vecs[1] = '{1'b0, 2'b01, 0, 1, SL};
        vecs[2] = '{1'b0, 2'b01, WRAP ? NP - 1 : 0, WRAP ? 1 : 0, WRAP ? SL : 0};
        vecs[3] = '{1'b0, 2'b11, WRAP ? NP - 1 : 0, 0, 0};
        vecs[4] = '{1'b0, 2'b00, WRAP ? NP - 1 : 0, 0, 0};
        vecs[5] = '{1'b1, 2'b10, 1, 1, SL};
        vecs[6] = '{1'b0, 2'b10, 2, 1, SL};
        vecs[7] = '{1'b0, 2'b10, 3, 1, SL};
        vecs[8] = '{1'b0, 2'b10, WRAP ? 0 : 3, WRAP ? 1 : 0, WRAP ? SL : 0};

        bus.iTRIGGER = 1'b0;
        bus.iGESTURE = 2'b00;
        model_reset();
        do_reset();

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].rst) do_reset();
            do_gesture(vecs[i].code, 2);
            check_int($sformatf("vec%0d_idx", i), int'(bus.oPHOTO_NUM), vecs[i].exp_idx);
            check_int($sformatf("vec%0d_steps", i), step_cnt, vecs[i].exp_steps);
            check_int($sformatf("vec%0d_busy", i), busy_cnt, vecs[i].exp_busy);
        end

        // Repeats during LOCK and a long hold must not step again.
        do_reset();
        busy_cnt = 0;
        step_cnt = 0;
        repeat (2)  tick(1'b1, 2'b10);
        repeat (6)  tick(1'b0, 2'b00);
        repeat (2)  tick(1'b1, 2'b10);
        repeat (2)  tick(1'b0, 2'b00);
        repeat (20) tick(1'b1, 2'b10);
        repeat (10) tick(1'b0, 2'b00);
        check_int("lock_idx", int'(bus.oPHOTO_NUM), 1);
        check_int("lock_steps", step_cnt, 1);
        check_int("lock_busy", busy_cnt, SL);
        do_gesture(2'b10, 3);
        check_int("after_release_idx", int'(bus.oPHOTO_NUM), 2);

        // Reset asserted in the middle of SLIDE clears everything at once.
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick(i < 2, 2'b10);
            seen = bus.oSLIDE_BUSY;
        end
        check_int("slide_reached", int'(seen), 1);
        tick(1'b0, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        check_int("midslide_reset_busy", int'(bus.oSLIDE_BUSY), 0);
        check_int("midslide_reset_pos", int'(bus.oSLIDE_POS), 0);
        check_int("midslide_reset_idx", int'(bus.oPHOTO_NUM), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        repeat (10) tick(1'b0, 2'b00);

        // Random traffic against the reference model.
        for (int n = 0; n < 150; n++) begin
            hold = $urandom_range(1, 6);
            g = 2'($urandom);
            for (int k = 0; k < hold; k++) begin
                if ($urandom_range(0, 3) == 0) g = 2'($urandom);
                tick(1'b1, g);
            end
            gap = $urandom_range(1, 20);
            for (int k = 0; k < gap; k++) tick(1'b0, 2'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
